spi_slave_cfg: RTL and testbench
================================

// Module: spi_slave_cfg
// PURPOSE
//  Parametrised SPI slave, successor to the fixed 8-bit spi_slave: configurable word width, SPI mode
//  (CPOL/CPHA), bit order and fill pattern, with a one-entry TX holding buffer and valid/ready handshakes.
//  SPI pins are oversampled in the clk27m domain. Sits between Tang Nano top-level pins and user logic.
//  Supports back-to-back words inside one cs frame.
// PARAMETERS
//  DATA_W       8      bits per SPI word (2..32)
//  CPOL         0      sclk idle level
//  CPHA         0      0: sample on leading edge / 1: sample on trailing edge
//  MSB_FIRST    1      1: MSB first on mosi/miso; 0: LSB first
//  SYNC_STAGES  2      synchroniser flops on sclk/cs/mosi (>=2)
//  TX_FILL      8'hFF  word shifted out on TX underrun (zero-extended/truncated to DATA_W)
// PORTS
//  clk27m      in   1       system clock
//  rst_n       in   1       synchronous active-low reset
//  sclk        in   1       SPI clock from master (asynchronous)
//  cs          in   1       chip select, active low (asynchronous)
//  mosi        in   1       master-out data
//  miso        out  1       slave-out data
//  miso_oe     out  1       1 while frame active (board tristate enable)
//  tx_data     in   DATA_W  word to send
//  tx_valid    in   1       tx_data valid
//  tx_ready    out  1       holding buffer empty; transfer when tx_valid&&tx_ready
//  tx_underrun out  1       1-cycle pulse: a word was committed from TX_FILL (buffer empty)
//  rx_data     out  DATA_W  last complete received word; held until next word
//  rx_valid    out  1       1-cycle pulse: rx_data updated (no backpressure)
//  rx_abort    out  1       1-cycle pulse: cs deasserted with partial word (1..DATA_W-1 bits)
//  busy        out  1       frame in progress (state ACTIVE)
// BEHAVIOUR
//  Reset (rst_n=0 at clk27m edge): state WAIT_IDLE; miso=CPOL-independent 0, miso_oe=0, tx_ready=1,
//   rx_data=0, all pulses 0, busy=0, buffers/counters cleared. Reset mid-frame discards everything.
//  Sync: sclk/cs/mosi through SYNC_STAGES flops, then one extra flop for edge detect. Events (one
//   clk27m cycle each): cs_fall, cs_rise, lead = sclk leaves CPOL, trail = sclk returns to CPOL.
//   sample_ev = CPHA ? trail : lead; shift_ev = CPHA ? lead : trail.
//  Timing: sclk high and low phases each >= SYNC_STAGES+2 clk27m cycles (3.375 MHz max at defaults).
//  FSM: WAIT_IDLE -> IDLE when synced cs=1 (a frame in progress at reset release is ignored).
//   IDLE -> ACTIVE on cs_fall. ACTIVE -> IDLE on cs_rise (takes priority over same-cycle sclk events).
//  TX: present event = cs_fall (CPHA=0 only) or shift_ev in ACTIVE. At present with tx_cnt==0: copy
//   buffer (or TX_FILL if empty) into tx_sh, drive first bit on miso. Buffer word is COMMITTED at the
//   word's first sample_ev: buffer cleared (tx_ready=1 next cycle); if TX_FILL was used, tx_underrun
//   pulses. cs_rise before commit leaves buffer untouched. Other presents drive next bit of tx_sh.
//   miso changes only at present events; holds between them. tx_valid while tx_ready=0 is ignored.
//   Buffer write and commit in same cycle: commit wins, new word accepted next cycle.
//  RX: each sample_ev shifts synced mosi into rx_sh, rx_cnt++. At rx_cnt==DATA_W-1 sample: rx_data
//   <= completed word, rx_valid=1 next cycle, rx_cnt wraps to 0. Pin edge to rx_valid = SYNC_STAGES+2.
//  cs_rise with rx_cnt!=0: partial word dropped, rx_abort pulse; rx_cnt/tx_cnt reset; miso_oe=0.
//  Counters are clog2(DATA_W) wide and wrap at DATA_W-1 -> 0; MSB_FIRST=0 mirrors shift direction.
// STRUCTURE
//  spi_defs.vh: state encodings (WAIT_IDLE/IDLE/ACTIVE), mode helper macros for sample/shift select.
//  Sub-module spi_sync_edge: SYNC_STAGES synchroniser + edge detector, outputs level/rise/fall;
//   instantiated for sclk, cs and mosi (mosi uses level only).
// TESTING
//  Mode0, DATA_W=8: preload 8'hA5, master sends 8'h3C -> miso bits 1010_0101, rx_data=8'h3C, one rx_valid.
//  Modes 1/2/3 each: same exchange -> identical rx_data/miso words; miso stable across every sample edge.
//  3 back-to-back words, one cs frame, tx loaded after each tx_ready -> 3 rx_valid, no tx_underrun.
//  Empty TX buffer, 1 word -> miso 8'hFF, tx_underrun pulses once at first sample edge.
//  cs_rise after 5 bits -> rx_abort once, no rx_valid; buffer preloaded but uncommitted keeps tx_ready=0.
//  Reset asserted mid-word with cs low -> outputs at reset values; no activity until cs high then low.

Source files
------------

// File: rtl/spi_slave_cfg_pkg.sv
// Shared types and SPI-mode edge helpers for the configurable SPI slave.
package spi_slave_cfg_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_IDLE = 2'd0,
    ST_IDLE      = 2'd1,
    ST_ACTIVE    = 2'd2
  } state_e;

  // Leading edge leaves the CPOL idle level; trailing edge returns to it.
  function automatic logic lead_sel(input logic cpol, input logic rise, input logic fall);
    return cpol ? fall : rise;
  endfunction

  function automatic logic trail_sel(input logic cpol, input logic rise, input logic fall);
    return cpol ? rise : fall;
  endfunction

  function automatic logic sample_sel(input logic cpha, input logic lead, input logic trail);
    return cpha ? trail : lead;
  endfunction

  function automatic logic shift_sel(input logic cpha, input logic lead, input logic trail);
    return cpha ? lead : trail;
  endfunction

endpackage

// File: rtl/spi_slave_cfg_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin plus a one-flop edge detector.
module spi_slave_cfg_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter bit          RST_VAL = 1'b0
) (
  input  logic clk27m,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk27m) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_cfg.sv
// SPI slave with configurable word width, mode and bit order, a one-entry TX holding buffer
// and valid/ready user handshakes; SPI pins are oversampled in the clk27m domain.
module spi_slave_cfg
  import spi_slave_cfg_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter bit          CPOL        = 1'b0,
  parameter bit          CPHA        = 1'b0,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] TX_FILL     = 32'h0000_00FF
) (
  input  logic              clk27m,
  input  logic              rst_n,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_abort,
  output logic              busy
);

  localparam int unsigned       CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0] FILL  = TX_FILL[DATA_W-1:0];

  state_e state_q, state_d;

  logic sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_lvl;

  logic lead, trail, sample_ev, shift_ev;
  logic in_frame, act_sample, act_shift, present, load_word, commit, frame_end;

  logic [DATA_W-1:0] tx_buf, tx_sh, next_word, tx_src, tx_shifted;
  logic [DATA_W-1:0] rx_sh, rx_word;
  logic              tx_full, from_buf, commit_pend, miso_next;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;

  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sync_sclk (
    .clk27m (clk27m),
    .rst_n  (rst_n),
    .din    (sclk),
    .level  (),
    .rise   (sclk_rise),
    .fall   (sclk_fall)
  );

  // cs resets to "selected" so a frame already running at reset release is never mistaken for idle.
  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_cs (
    .clk27m (clk27m),
    .rst_n  (rst_n),
    .din    (cs),
    .level  (cs_lvl),
    .rise   (cs_rise),
    .fall   (cs_fall)
  );

  spi_slave_cfg_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk27m (clk27m),
    .rst_n  (rst_n),
    .din    (mosi),
    .level  (mosi_lvl),
    .rise   (),
    .fall   ()
  );

  assign lead      = lead_sel(CPOL, sclk_rise, sclk_fall);
  assign trail     = trail_sel(CPOL, sclk_rise, sclk_fall);
  assign sample_ev = sample_sel(CPHA, lead, trail);
  assign shift_ev  = shift_sel(CPHA, lead, trail);

  // cs_rise ends the frame and masks any sclk event seen in the same cycle.
  assign in_frame   = (state_q == ST_ACTIVE) && !cs_rise;
  assign frame_end  = (state_q == ST_ACTIVE) && cs_rise;
  assign act_sample = in_frame && sample_ev;
  assign act_shift  = in_frame && shift_ev;
  assign present    = act_shift || ((state_q == ST_IDLE) && cs_fall && !CPHA);
  assign load_word  = present && (tx_cnt == '0);
  assign commit     = act_sample && (rx_cnt == '0) && commit_pend;

  assign next_word  = tx_full ? tx_buf : FILL;
  assign tx_src     = load_word ? next_word : tx_sh;
  assign miso_next  = MSB_FIRST ? tx_src[DATA_W-1] : tx_src[0];
  assign tx_shifted = MSB_FIRST ? {tx_src[DATA_W-2:0], 1'b0} : {1'b0, tx_src[DATA_W-1:1]};
  assign rx_word    = MSB_FIRST ? {rx_sh[DATA_W-2:0], mosi_lvl} : {mosi_lvl, rx_sh[DATA_W-1:1]};

  always_ff @(posedge clk27m) begin
    if (!rst_n) state_q <= ST_WAIT_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: next-state gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_WAIT_IDLE: if (cs_lvl)  state_d = ST_IDLE;
      ST_IDLE:      if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE:    if (cs_rise) state_d = ST_IDLE;
      default:                   state_d = ST_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk27m) begin
    if (!rst_n) begin
      // NOTE: buffers and shifters are reset too, since a mid-frame reset must discard everything.
      miso        <= 1'b0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_sh       <= '0;
      from_buf    <= 1'b0;
      commit_pend <= 1'b0;
      tx_cnt      <= '0;
      rx_sh       <= '0;
      rx_cnt      <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;

      if (tx_valid && !tx_full) begin
        tx_buf  <= tx_data;
        tx_full <= 1'b1;
      end

      if (present) begin
        miso   <= miso_next;
        tx_sh  <= tx_shifted;
        tx_cnt <= (tx_cnt == LAST) ? '0 : tx_cnt + 1'b1;
        if (load_word) begin
          from_buf    <= tx_full;
          commit_pend <= 1'b1;
        end
      end

      // The buffer is only released once the master has actually clocked the word's first bit.
      if (commit) begin
        commit_pend <= 1'b0;
        if (from_buf) tx_full     <= 1'b0;
        else          tx_underrun <= 1'b1;
      end

      if (act_sample) begin
        rx_sh <= rx_word;
        if (rx_cnt == LAST) begin
          rx_data  <= rx_word;
          rx_valid <= 1'b1;
          rx_cnt   <= '0;
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end

      if (frame_end) begin
        rx_abort    <= (rx_cnt != '0);
        rx_cnt      <= '0;
        tx_cnt      <= '0;
        commit_pend <= 1'b0;
      end
    end
  end

  assign tx_ready = !tx_full;
  assign busy     = (state_q == ST_ACTIVE);
  assign miso_oe  = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave_cfg.sv
// Directed bench: one DUT per SPI mode (index = {CPOL,CPHA}), DATA_W=8, MSB first.
module tb_spi_slave_cfg;

  localparam int HALF = 10;

  logic       clk27m = 1'b0;
  logic       rst_n;
  logic [3:0] sclk, cs, mosi, miso, miso_oe, tx_valid, tx_ready, tx_underrun;
  logic [3:0] rx_valid, rx_abort, busy;
  logic [7:0] tx_data [4];
  logic [7:0] rx_data [4];

  int n_rxv [4];
  int n_und [4];
  int n_abt [4];
  int total = 0;
  int bad   = 0;
  int und_bit0;

  always #5 clk27m = ~clk27m;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_cfg #(
      .DATA_W(8), .CPOL(1'(g / 2)), .CPHA(1'(g % 2)), .MSB_FIRST(1'b1),
      .SYNC_STAGES(2), .TX_FILL(32'hFF)
    ) u_dut (
      .clk27m      (clk27m),
      .rst_n       (rst_n),
      .sclk        (sclk[g]),
      .cs          (cs[g]),
      .mosi        (mosi[g]),
      .miso        (miso[g]),
      .miso_oe     (miso_oe[g]),
      .tx_data     (tx_data[g]),
      .tx_valid    (tx_valid[g]),
      .tx_ready    (tx_ready[g]),
      .tx_underrun (tx_underrun[g]),
      .rx_data     (rx_data[g]),
      .rx_valid    (rx_valid[g]),
      .rx_abort    (rx_abort[g]),
      .busy        (busy[g])
    );
  end

  always @(posedge clk27m) begin
    for (int m = 0; m < 4; m++) begin
      if (rx_valid[m] === 1'b1)    n_rxv[m]++;
      if (tx_underrun[m] === 1'b1) n_und[m]++;
      if (rx_abort[m] === 1'b1)    n_abt[m]++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk27m);
  endtask

  task automatic load_tx(input int m, input logic [7:0] w);
    int t;
    t = 0;
    while (tx_ready[m] !== 1'b1 && t < 100) begin
      tick(1);
      t++;
    end
    total++;
    if (tx_ready[m] !== 1'b1) begin
      bad++;
      $display("FAIL load_tx_ready m=%0d got=%b want=1", m, tx_ready[m]);
    end
    tx_data[m]  = w;
    tx_valid[m] = 1'b1;
    tick(1);
    tx_valid[m] = 1'b0;
  endtask

  // One sclk edge preceded by HALF cycles; on sample edges capture miso and check it is steady around the edge.
  task automatic half_edge(input int m, input logic lvl, input bit smp,
                           inout logic [7:0] mi, inout bit stable);
    logic a, v, b;
    tick(HALF - 3);
    a = miso[m];
    tick(3);
    v = miso[m];
    sclk[m] = lvl;
    tick(3);
    b = miso[m];
    if (smp) begin
      mi = {mi[6:0], v};
      if (a !== v || b !== v) stable = 1'b0;
    end
  endtask

  task automatic spi_bits(input int m, input int nb, input logic [7:0] mo, input bit ld,
                          input logic [7:0] ldw, output logic [7:0] mi, output bit stable);
    bit   h;
    logic p;
    h = (m % 2) == 1;
    p = (m / 2) == 1;
    mi = '0;
    stable = 1'b1;
    for (int i = 0; i < nb; i++) begin
      if (!h) mosi[m] = mo[7-i];
      half_edge(m, ~p, !h, mi, stable);
      if (h) mosi[m] = mo[7-i];
      half_edge(m, p, h, mi, stable);
      if (i == 0) und_bit0 = n_und[m];
      if (i == 0 && ld) load_tx(m, ldw);
    end
  endtask

  task automatic cs_end(input int m);
    tick(HALF);
    cs[m] = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic test_reset;
    rst_n    = 1'b0;
    sclk     = 4'b1100;
    cs       = 4'b1111;
    mosi     = 4'b0000;
    tx_valid = 4'b0000;
    for (int m = 0; m < 4; m++) tx_data[m] = 8'h00;
    tick(4);
    for (int m = 0; m < 4; m++) begin
      total++;
      if ({miso[m], miso_oe[m], tx_ready[m], tx_underrun[m], rx_valid[m], rx_abort[m], busy[m]} !== 7'b0010000) begin
        bad++;
        $display("FAIL reset_outputs m=%0d got=%b want=0010000", m,
                 {miso[m], miso_oe[m], tx_ready[m], tx_underrun[m], rx_valid[m], rx_abort[m], busy[m]});
      end
      total++;
      if (rx_data[m] !== 8'h00) begin bad++; $display("FAIL reset_rx_data m=%0d got=%h want=00", m, rx_data[m]); end
    end
    rst_n = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic test_modes;
    logic [7:0] mi;
    bit         st;
    int         r0, u0, a0;
    for (int m = 0; m < 4; m++) begin
      r0 = n_rxv[m]; u0 = n_und[m]; a0 = n_abt[m];
      load_tx(m, 8'hA5);
      cs[m] = 1'b0;
      tick(5);
      total++;
      if ({busy[m], miso_oe[m]} !== 2'b11) begin bad++; $display("FAIL mode_busy m=%0d got=%b want=11", m, {busy[m], miso_oe[m]}); end
      spi_bits(m, 8, 8'h3C, 1'b0, 8'h00, mi, st);
      cs_end(m);
      total++;
      if (mi !== 8'hA5) begin bad++; $display("FAIL mode_miso m=%0d got=%h want=a5", m, mi); end
      total++;
      if (rx_data[m] !== 8'h3C) begin bad++; $display("FAIL mode_rx_data m=%0d got=%h want=3c", m, rx_data[m]); end
      total++;
      if (n_rxv[m] - r0 !== 1) begin bad++; $display("FAIL mode_rx_valid m=%0d got=%0d want=1", m, n_rxv[m] - r0); end
      total++;
      if (n_und[m] - u0 !== 0 || n_abt[m] - a0 !== 0) begin
        bad++; $display("FAIL mode_pulses m=%0d und=%0d abt=%0d want=0/0", m, n_und[m] - u0, n_abt[m] - a0);
      end
      total++;
      if (st !== 1'b1) begin bad++; $display("FAIL mode_miso_stable m=%0d got=%b want=1", m, st); end
      total++;
      if ({busy[m], miso_oe[m], tx_ready[m]} !== 3'b001) begin
        bad++; $display("FAIL mode_end_state m=%0d got=%b want=001", m, {busy[m], miso_oe[m], tx_ready[m]});
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] txw [3];
    logic [7:0] mow [3];
    logic [7:0] mi;
    bit         st;
    int         r0, u0;
    txw = '{8'h81, 8'h42, 8'hE7};
    mow = '{8'hC3, 8'h5A, 8'h0F};
    r0 = n_rxv[0]; u0 = n_und[0];
    load_tx(0, txw[0]);
    cs[0] = 1'b0;
    for (int w = 0; w < 3; w++) begin
      spi_bits(0, 8, mow[w], w < 2, (w < 2) ? txw[(w + 1) % 3] : 8'h00, mi, st);
      total++;
      if (mi !== txw[w]) begin bad++; $display("FAIL b2b_miso w=%0d got=%h want=%h", w, mi, txw[w]); end
      total++;
      if (rx_data[0] !== mow[w]) begin bad++; $display("FAIL b2b_rx_data w=%0d got=%h want=%h", w, rx_data[0], mow[w]); end
    end
    cs_end(0);
    total++;
    if (n_rxv[0] - r0 !== 3) begin bad++; $display("FAIL b2b_rx_valid got=%0d want=3", n_rxv[0] - r0); end
    total++;
    if (n_und[0] - u0 !== 0) begin bad++; $display("FAIL b2b_underrun got=%0d want=0", n_und[0] - u0); end
  endtask

  task automatic test_underrun;
    logic [7:0] mi;
    bit         st;
    int         u0;
    u0 = n_und[0];
    cs[0] = 1'b0;
    spi_bits(0, 8, 8'h24, 1'b0, 8'h00, mi, st);
    cs_end(0);
    total++;
    if (mi !== 8'hFF) begin bad++; $display("FAIL und_miso got=%h want=ff", mi); end
    total++;
    if (und_bit0 - u0 !== 1) begin bad++; $display("FAIL und_at_first_bit got=%0d want=1", und_bit0 - u0); end
    total++;
    if (n_und[0] - u0 !== 1) begin bad++; $display("FAIL und_count got=%0d want=1", n_und[0] - u0); end
    total++;
    if (rx_data[0] !== 8'h24) begin bad++; $display("FAIL und_rx_data got=%h want=24", rx_data[0]); end
  endtask

  task automatic test_abort;
    logic [7:0] mi;
    bit         st;
    int         r0, a0;
    r0 = n_rxv[0]; a0 = n_abt[0];
    load_tx(0, 8'h5A);
    cs[0] = 1'b0;
    spi_bits(0, 5, 8'hF0, 1'b1, 8'h77, mi, st);
    cs_end(0);
    total++;
    if (n_abt[0] - a0 !== 1) begin bad++; $display("FAIL abort_count got=%0d want=1", n_abt[0] - a0); end
    total++;
    if (n_rxv[0] - r0 !== 0) begin bad++; $display("FAIL abort_rx_valid got=%0d want=0", n_rxv[0] - r0); end
    total++;
    if (rx_data[0] !== 8'h24) begin bad++; $display("FAIL abort_rx_held got=%h want=24", rx_data[0]); end
    total++;
    if ({tx_ready[0], busy[0]} !== 2'b00) begin bad++; $display("FAIL abort_state got=%b want=00", {tx_ready[0], busy[0]}); end
    cs[0] = 1'b0;
    spi_bits(0, 8, 8'h18, 1'b0, 8'h00, mi, st);
    cs_end(0);
    total++;
    if (mi !== 8'h77) begin bad++; $display("FAIL abort_next_miso got=%h want=77", mi); end
    total++;
    if (rx_data[0] !== 8'h18) begin bad++; $display("FAIL abort_next_rx got=%h want=18", rx_data[0]); end
  endtask

  task automatic test_reset_midword;
    logic [7:0] mi;
    bit         st;
    int         r0;
    load_tx(0, 8'h96);
    cs[0] = 1'b0;
    spi_bits(0, 3, 8'hAA, 1'b1, 8'hC6, mi, st);
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
    total++;
    if ({miso[0], miso_oe[0], tx_ready[0], tx_underrun[0], rx_valid[0], rx_abort[0], busy[0]} !== 7'b0010000) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=0010000",
               {miso[0], miso_oe[0], tx_ready[0], tx_underrun[0], rx_valid[0], rx_abort[0], busy[0]});
    end
    total++;
    if (rx_data[0] !== 8'h00) begin bad++; $display("FAIL midrst_rx_data got=%h want=00", rx_data[0]); end
    r0 = n_rxv[0];
    spi_bits(0, 8, 8'hFF, 1'b0, 8'h00, mi, st);
    total++;
    if ({n_rxv[0] - r0, busy[0], miso_oe[0]} !== {32'd0, 2'b00}) begin
      bad++; $display("FAIL midrst_ignored rxv=%0d busy=%b oe=%b want=0/0/0", n_rxv[0] - r0, busy[0], miso_oe[0]);
    end
    cs_end(0);
    load_tx(0, 8'h3C);
    cs[0] = 1'b0;
    spi_bits(0, 8, 8'h69, 1'b0, 8'h00, mi, st);
    cs_end(0);
    total++;
    if (mi !== 8'h3C) begin bad++; $display("FAIL midrst_after_miso got=%h want=3c", mi); end
    total++;
    if (rx_data[0] !== 8'h69) begin bad++; $display("FAIL midrst_after_rx got=%h want=69", rx_data[0]); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_modes;
    test_back_to_back;
    test_underrun;
    test_abort;
    test_reset_midword;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
